// File: rtl/stream_sel_mux.sv
// stream_sel_mux: N:1 streaming multiplexer with valid/ready handshakes and
// packet-atomic channel switching. A channel is chosen either by a fixed
// select or by round-robin arbitration. It is then held until its beat
// marked last has been accepted. Accepted beats pass through one registered
// output stage.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   in_data         NUM_CH packed beats, channel i at [i*WIDTH +: WIDTH]
//   in_valid        per-channel beat valid
//   in_last         per-channel last-beat flag
//   in_ready        per-channel ready; at most one bit is high (granted channel)
//   sel, mode       fixed channel select / 0 = fixed, 1 = round-robin
//   enable          permits a new grant; only looked at while idle
//   out_data        registered beat data
//   out_valid       registered beat valid
//   out_last        registered last flag
//   out_ch          registered source channel
//   out_ready       downstream ready
//   sel_err         registered pulse for each idle cycle with an illegal fixed select
module stream_sel_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    enable,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic             sel_err_d;

  logic             sel_legal;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [WIDTH-1:0] grant_data;
  logic             grant_valid, grant_last;
  logic             pop_ok, accept;

  logic [WIDTH-1:0] data_p0;
  logic             vld_p0, last_p0;
  logic [SEL_W-1:0] ch_p0;

  assign sel_legal = ({1'b0, sel} < NUM_CH_W);

  // Granted-channel view of the input bus
  always_comb begin
    grant_data  = '0;
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        grant_valid = in_valid[i];
        grant_last  = in_last[i];
      end
    end
  end

  // Round-robin search starts one past the previous winner and wraps at
  // NUM_CH, which need not be a power of two.
  always_comb begin
    int               cand;
    logic [SEL_W-1:0] cand_idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = SEL_W'(cand);
      if (!rr_found && in_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // The output register can take a beat when it is empty or is being drained.
  assign pop_ok = !vld_p0 || out_ready;
  assign accept = (state_q == LOCKED) && grant_valid && pop_ok;

  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_q == SEL_W'(i)) in_ready[i] = pop_ok;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sel_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (!mode) begin
            if (sel_legal) begin
              grant_d = sel;
              state_d = LOCKED;
            end else begin
              sel_err_d = 1'b1;
            end
          end else if (rr_found) begin
            grant_d      = rr_idx;
            last_grant_d = rr_idx;
            state_d      = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept && grant_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      sel_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sel_err      <= sel_err_d;
    end
  end

  // ---- stage p0: registered output beat ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
      last_p0 <= 1'b0;
      ch_p0   <= '0;
      vld_p0  <= 1'b0;
    end else if (accept) begin
      data_p0 <= grant_data;
      last_p0 <= grant_last;
      ch_p0   <= grant_q;
      vld_p0  <= 1'b1;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_data  = data_p0;
  assign out_last  = last_p0;
  assign out_ch    = ch_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_stream_sel_mux.sv
// tb_stream_sel_mux: directed bench for stream_sel_mux (7 channels, so that
// select value 7 is illegal and the round-robin wrap is not a power of two).
// Expected beats are queued by the stimulus code; a monitor pops them on
// each output transfer and also checks that a stalled beat holds steady.
module tb_stream_sel_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 7;
  localparam int SEL_W  = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [2:0] ch;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_last;
  logic [NUM_CH-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic                    enable;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_last;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;
  logic                    sel_err;

  logic [WIDTH-1:0] ch_data [NUM_CH];

  beat_t sb[$];
  int    pop_cyc[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign in_data[g*WIDTH +: WIDTH] = ch_data[g];
  end

  stream_sel_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sel(sel), .mode(mode), .enable(enable),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] d, input logic l, input logic [2:0] ch);
    beat_t b;
    b.d = d; b.l = l; b.ch = ch;
    return b;
  endfunction

  task automatic monitor_loop();
    beat_t got, exp_b, held;
    bit    stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall)
          check("stall_hold", 32'({out_valid, out_data, out_last, out_ch}), 32'({1'b1, held}));
        if (out_valid && out_ready) begin
          got = mk(out_data, out_last, out_ch);
          pop_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got 0x%0h, expected none", got);
          end else begin
            exp_b = sb.pop_front();
            check("beat", 32'(got), 32'(exp_b));
          end
        end
        stall = out_valid && !out_ready;
        held  = mk(out_data, out_last, out_ch);
      end
    end
  endtask

  // Offer one beat on a channel and return just after it has been accepted.
  task automatic send_beat(input logic [2:0] ch, input logic [7:0] d, input logic l);
    int t;
    ch_data[ch]  = d;
    in_last[ch]  = l;
    in_valid[ch] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[ch] && t < 200);
    if (!in_ready[ch]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ch %0d data 0x%0h never accepted, expected acceptance", ch, d);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) ch_data[i] = '0;
    in_valid  = '0;
    in_last   = '0;
    sel       = '0;
    mode      = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_sel_err",   32'(sel_err),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fixed select, ch3, 4-beat packet, no backpressure
    sb.push_back(mk(8'hA0, 1'b0, 3'd3));
    sb.push_back(mk(8'hA1, 1'b0, 3'd3));
    sb.push_back(mk(8'hA2, 1'b0, 3'd3));
    sb.push_back(mk(8'hA3, 1'b1, 3'd3));
    mode = 1'b0;
    sel  = 3'd3;
    fork
      begin
        send_beat(3'd3, 8'hA0, 1'b0);
        send_beat(3'd3, 8'hA1, 1'b0);
        send_beat(3'd3, 8'hA2, 1'b0);
        send_beat(3'd3, 8'hA3, 1'b1);
      end
      pulse_enable();
      begin
        int n = 0;
        repeat (10) begin
          @(negedge clk);
          if (in_ready[3]) n++;
        end
        check("fixed_in_ready_cycles", 32'(n), 32'd4);
      end
    join
    @(posedge clk); #1;

    // Backpressure: downstream stalls for 3 cycles after the first beat
    sb.push_back(mk(8'hB0, 1'b0, 3'd3));
    sb.push_back(mk(8'hB1, 1'b0, 3'd3));
    sb.push_back(mk(8'hB2, 1'b0, 3'd3));
    sb.push_back(mk(8'hB3, 1'b1, 3'd3));
    out_ready = 1'b0;
    fork
      begin
        send_beat(3'd3, 8'hB0, 1'b0);
        send_beat(3'd3, 8'hB1, 1'b0);
        send_beat(3'd3, 8'hB2, 1'b0);
        send_beat(3'd3, 8'hB3, 1'b1);
      end
      pulse_enable();
      begin
        int t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 50);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check("bp_out_valid", 32'(out_valid),   32'd1);
          check("bp_out_data",  32'(out_data),    32'hB0);
          check("bp_in_ready3", 32'(in_ready[3]), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Round-robin over ch1, ch4, ch6 with single-beat packets
    sb.push_back(mk(8'h11, 1'b1, 3'd1));
    sb.push_back(mk(8'h41, 1'b1, 3'd4));
    sb.push_back(mk(8'h61, 1'b1, 3'd6));
    sb.push_back(mk(8'h12, 1'b1, 3'd1));
    sb.push_back(mk(8'h42, 1'b1, 3'd4));
    sb.push_back(mk(8'h62, 1'b1, 3'd6));
    pop_cyc.delete();
    mode   = 1'b1;
    enable = 1'b1;
    fork
      begin send_beat(3'd1, 8'h11, 1'b1); send_beat(3'd1, 8'h12, 1'b1); end
      begin send_beat(3'd4, 8'h41, 1'b1); send_beat(3'd4, 8'h42, 1'b1); end
      begin send_beat(3'd6, 8'h61, 1'b1); send_beat(3'd6, 8'h62, 1'b1); end
    join
    enable = 1'b0;
    @(negedge clk); #1;
    check("rr_beat_count", 32'(pop_cyc.size()), 32'd6);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("rr_beat_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    @(posedge clk); #1;

    // Select/enable changes mid-packet are ignored; next grant uses new sel
    sb.push_back(mk(8'hC0, 1'b0, 3'd2));
    sb.push_back(mk(8'hC1, 1'b0, 3'd2));
    sb.push_back(mk(8'hC2, 1'b0, 3'd2));
    sb.push_back(mk(8'hC3, 1'b0, 3'd2));
    sb.push_back(mk(8'hC4, 1'b1, 3'd2));
    sb.push_back(mk(8'hD0, 1'b1, 3'd5));
    mode   = 1'b0;
    sel    = 3'd2;
    enable = 1'b1;
    fork
      begin
        send_beat(3'd2, 8'hC0, 1'b0);
        send_beat(3'd2, 8'hC1, 1'b0);
        send_beat(3'd2, 8'hC2, 1'b0);
        send_beat(3'd2, 8'hC3, 1'b0);
        send_beat(3'd2, 8'hC4, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        sel    = 3'd5;
        enable = 1'b0;
      end
    join
    fork
      send_beat(3'd5, 8'hD0, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk);
          check("hold_idle_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        pulse_enable();
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Illegal fixed select
    mode   = 1'b0;
    sel    = 3'd7;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("illegal_sel_err",   32'(sel_err),   32'd1);
      check("illegal_in_ready",  32'(in_ready),  32'd0);
      check("illegal_out_valid", 32'(out_valid), 32'd0);
    end
    enable = 1'b0;
    @(negedge clk);
    check("illegal_sel_err_clear", 32'(sel_err), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a round-robin packet on ch4
    sb.push_back(mk(8'hE0, 1'b0, 3'd4));
    mode   = 1'b1;
    sel    = 3'd0;
    enable = 1'b1;
    send_beat(3'd4, 8'hE0, 1'b0);
    send_beat(3'd4, 8'hE1, 1'b0);
    rst_n  = 1'b0;
    enable = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_out_last",  32'(out_last),  32'd0);
    check("midrst_out_ch",    32'(out_ch),    32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // After reset the round-robin pointer restarts at channel 0
    sb.push_back(mk(8'hF0, 1'b1, 3'd0));
    sb.push_back(mk(8'hF5, 1'b1, 3'd5));
    enable = 1'b1;
    fork
      send_beat(3'd0, 8'hF0, 1'b1);
      send_beat(3'd5, 8'hF5, 1'b1);
    join
    enable = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
